// File: rtl/rv_pkg.sv
// Shared register-file write-path types: sizes, queued write entry, rd decode helper.
package rv_pkg;

  localparam int REG_CNT = 32;
  localparam int AW      = 5;
  localparam int DW      = 32;

  typedef struct packed {
    logic          live;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  // One-hot decode of a register index onto the pending mask.
  function automatic logic [REG_CNT-1:0] rd_onehot(input logic [AW-1:0] rd);
    rd_onehot = {{(REG_CNT-1){1'b0}}, 1'b1} << rd;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending load writes; an ALU write kills every entry with the same rd,
// including one being pushed in that same cycle.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [AW-1:0]      push_rd,
  input  logic [DW-1:0]      push_data,
  input  logic               pop,
  input  logic               kill_en,
  input  logic [AW-1:0]      kill_rd,
  output wb_entry_t          head,
  output logic               empty,
  output logic               full,
  output logic [CW-1:0]      count,
  output logic [REG_CNT-1:0] pending_mask
);

  wb_entry_t       mem_r [DEPTH];
  logic [CW-1:0]   wr_ptr_r;
  logic [CW-1:0]   rd_ptr_r;
  logic [CW-2:0]   wr_idx_s;
  logic [CW-2:0]   rd_idx_s;
  logic            push_ok_s;
  logic            pop_ok_s;

  assign wr_idx_s  = wr_ptr_r[CW-2:0];
  assign rd_idx_s  = rd_ptr_r[CW-2:0];
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_idx_s == rd_idx_s) && (wr_ptr_r[CW-1] != rd_ptr_r[CW-1]);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign head      = mem_r[rd_idx_s];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Entry storage and pointers; popped slots are marked dead so only occupied slots can be live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (mem_r[i].rd == kill_rd)) begin
          mem_r[i].live <= 1'b0;
        end
      end
      if (pop_ok_s) begin
        mem_r[rd_idx_s].live <= 1'b0;
        rd_ptr_r             <= rd_ptr_r + CW'(1);
      end
      if (push_ok_s) begin
        mem_r[wr_idx_s].live <= !(kill_en && (push_rd == kill_rd));
        mem_r[wr_idx_s].rd   <= push_rd;
        mem_r[wr_idx_s].data <= push_data;
        wr_ptr_r             <= wr_ptr_r + CW'(1);
      end
    end
  end

  // OR of the decoded rd of every live slot; x0 never reads as pending.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_mask = pending_mask | (mem_r[i].live ? rd_onehot(mem_r[i].rd) : {REG_CNT{1'b0}});
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Register-file write port arbiter: ALU results take priority, load returns queue behind them,
// and an ALU write supersedes any older queued load to the same register.
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = rv_pkg::DW,
  parameter int AW    = rv_pkg::AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [AW-1:0]          alu_rd,
  input  logic [DW-1:0]          alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [AW-1:0]          ld_rd,
  input  logic [DW-1:0]          ld_data,
  output logic                   Register_write,
  output logic [AW-1:0]          Rd,
  output logic [DW-1:0]          WriteData,
  output logic [31:0]            pending_mask,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  rv_pkg::wb_entry_t head_s;
  logic              empty_s;
  logic              full_s;
  logic              alu_issue_s;
  logic              pop_s;
  logic              push_s;

  assign ld_ready = !full_s;

  // Issue selection: a non-x0 ALU write wins; otherwise the queue head pops.
  always_comb begin
    alu_issue_s = 1'b0;
    pop_s       = 1'b0;
    push_s      = 1'b0;
    alu_issue_s = alu_valid && (alu_rd != {AW{1'b0}});
    pop_s       = !alu_issue_s && !empty_s;
    push_s      = ld_valid && !full_s && (ld_rd != {AW{1'b0}});
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push_s),
    .push_rd      (ld_rd),
    .push_data    (ld_data),
    .pop          (pop_s),
    .kill_en      (alu_issue_s),
    .kill_rd      (alu_rd),
    .head         (head_s),
    .empty        (empty_s),
    .full         (full_s),
    .count        (q_count),
    .pending_mask (pending_mask)
  );

  // Registered write port; index and data hold when nothing issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Register_write <= 1'b0;
      Rd             <= '0;
      WriteData      <= '0;
    end else begin
      Register_write <= alu_issue_s || (pop_s && head_s.live);
      if (alu_issue_s) begin
        Rd        <= alu_rd;
        WriteData <= alu_data;
      end else if (pop_s && head_s.live) begin
        Rd        <= head_s.rd;
        WriteData <= head_s.data;
      end else begin
        Rd        <= Rd;
        WriteData <= WriteData;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: reset, single load, priority/fill, order hazard,
// x0 filtering and pointer wrap-around.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        Register_write;
  logic [4:0]  Rd;
  logic [31:0] WriteData;
  logic [31:0] pending_mask;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  log_rd[$];
  logic [31:0] log_data[$];

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .Register_write (Register_write),
    .Rd             (Rd),
    .WriteData      (WriteData),
    .pending_mask   (pending_mask),
    .q_count        (q_count)
  );

  // Every strobed write is visible across a falling edge exactly once.
  always @(negedge clk) begin
    if (reset && Register_write) begin
      log_rd.push_back(Rd);
      log_data.push_back(WriteData);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = 32'h0;
  endtask

  task automatic clear_log();
    log_rd.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    repeat (2) step();
    reset = 1'b1;
    step();
    n_checks++; if (Register_write !== 1'b0) begin n_fail++; $display("FAIL rst_wr got %b exp 0", Register_write); end
    n_checks++; if (Rd !== 5'd0) begin n_fail++; $display("FAIL rst_rd got %0d exp 0", Rd); end
    n_checks++; if (WriteData !== 32'h0) begin n_fail++; $display("FAIL rst_data got %h exp 0", WriteData); end
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", ld_ready); end
    n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL rst_mask got %h exp 0", pending_mask); end
    n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", q_count); end
    // queue three loads behind continuous ALU traffic, then reset mid-stream
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd15; alu_data = 32'hF0 + i;
      ld_valid  = 1'b1; ld_rd  = 5'(i + 1); ld_data = 32'h500 + i;
      step();
    end
    n_checks++; if (q_count !== 3'd3) begin n_fail++; $display("FAIL rst_prefill got %0d exp 3", q_count); end
    idle();
    #2 reset = 1'b0;
    #1;
    n_checks++; if (Register_write !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wr got %b exp 0", Register_write); end
    n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count got %0d exp 0", q_count); end
    n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL rst_mid_mask got %h exp 0", pending_mask); end
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b exp 1", ld_ready); end
    repeat (2) step();
    reset = 1'b1;
    clear_log();
    repeat (6) step();
    n_checks++; if (log_rd.size() !== 0) begin n_fail++; $display("FAIL rst_no_write got %0d writes exp 0", log_rd.size()); end
  endtask

  task automatic test_single_load();
    clear_log();
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hDEAD;
    step();
    idle();
    n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", q_count); end
    n_checks++; if (pending_mask !== 32'h20) begin n_fail++; $display("FAIL single_mask_set got %h exp 20", pending_mask); end
    n_checks++; if (Register_write !== 1'b0) begin n_fail++; $display("FAIL single_early_wr got %b exp 0", Register_write); end
    step();
    n_checks++; if (Register_write !== 1'b1) begin n_fail++; $display("FAIL single_wr got %b exp 1", Register_write); end
    n_checks++; if (Rd !== 5'd5) begin n_fail++; $display("FAIL single_rd got %0d exp 5", Rd); end
    n_checks++; if (WriteData !== 32'hDEAD) begin n_fail++; $display("FAIL single_data got %h exp dead", WriteData); end
    n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL single_mask_clr got %h exp 0", pending_mask); end
    step();
    n_checks++; if (Register_write !== 1'b0) begin n_fail++; $display("FAIL single_wr_drop got %b exp 0", Register_write); end
    n_checks++; if (Rd !== 5'd5) begin n_fail++; $display("FAIL single_rd_hold got %0d exp 5", Rd); end
    n_checks++; if (log_rd.size() !== 1) begin n_fail++; $display("FAIL single_writes got %0d exp 1", log_rd.size()); end
  endtask

  task automatic test_priority_fill();
    logic [4:0]  exp_rd[9];
    logic [31:0] exp_data[9];
    clear_log();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA00 + i;
      ld_valid  = 1'b1; ld_rd  = 5'(i + 1);  ld_data  = 32'h100 + i;
      n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d got %b exp 1", i, ld_ready); end
      step();
    end
    n_checks++; if (q_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", q_count); end
    n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL fill_not_ready got %b exp 0", ld_ready); end
    n_checks++; if (pending_mask !== 32'h1E) begin n_fail++; $display("FAIL fill_mask got %h exp 1e", pending_mask); end
    alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'hA04;
    ld_valid  = 1'b1; ld_rd  = 5'd9;  ld_data  = 32'h999;
    step();
    n_checks++; if (q_count !== 3'd4) begin n_fail++; $display("FAIL fill_full_hold got %0d exp 4", q_count); end
    n_checks++; if (pending_mask !== 32'h1E) begin n_fail++; $display("FAIL fill_mask_hold got %h exp 1e", pending_mask); end
    idle();
    repeat (8) step();
    n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL fill_drained got %0d exp 0", q_count); end
    for (int i = 0; i < 5; i++) begin exp_rd[i] = 5'(10 + i); exp_data[i] = 32'hA00 + i; end
    for (int i = 0; i < 4; i++) begin exp_rd[5 + i] = 5'(i + 1); exp_data[5 + i] = 32'h100 + i; end
    n_checks++;
    if (log_rd.size() !== 9) begin
      n_fail++; $display("FAIL fill_writes got %0d exp 9", log_rd.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (log_rd[i] !== exp_rd[i] || log_data[i] !== exp_data[i]) begin
          n_fail++;
          $display("FAIL fill_order_%0d got rd=%0d data=%h exp rd=%0d data=%h", i, log_rd[i], log_data[i], exp_rd[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_order_hazard();
    clear_log();
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h55;
    ld_valid  = 1'b1; ld_rd  = 5'd7;  ld_data  = 32'h11;
    step();
    n_checks++; if (pending_mask !== 32'h80) begin n_fail++; $display("FAIL hz_mask_set got %h exp 80", pending_mask); end
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h22;
    ld_valid  = 1'b0;
    step();
    n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL hz_mask_clr got %h exp 0", pending_mask); end
    n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL hz_killed_count got %0d exp 1", q_count); end
    n_checks++; if (Rd !== 5'd7 || WriteData !== 32'h22) begin n_fail++; $display("FAIL hz_alu_write got rd=%0d data=%h exp rd=7 data=22", Rd, WriteData); end
    idle();
    step();
    n_checks++; if (Register_write !== 1'b0) begin n_fail++; $display("FAIL hz_killed_pop_wr got %b exp 0", Register_write); end
    n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL hz_killed_popped got %0d exp 0", q_count); end
    // same-cycle ALU write and load return to one register
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
    ld_valid  = 1'b1; ld_rd  = 5'd8; ld_data  = 32'h77;
    step();
    idle();
    n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL hz_same_count got %0d exp 1", q_count); end
    n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL hz_same_mask got %h exp 0", pending_mask); end
    step();
    n_checks++; if (Register_write !== 1'b0 || q_count !== 3'd0) begin n_fail++; $display("FAIL hz_same_pop got wr=%b count=%0d exp wr=0 count=0", Register_write, q_count); end
    step();
    n_checks++;
    if (log_rd.size() !== 3) begin
      n_fail++; $display("FAIL hz_writes got %0d exp 3", log_rd.size());
    end else if (log_rd[1] !== 5'd7 || log_data[1] !== 32'h22 || log_rd[2] !== 5'd8 || log_data[2] !== 32'h88) begin
      n_fail++; $display("FAIL hz_final got x7=%h x8=%h exp x7=22 x8=88", log_data[1], log_data[2]);
    end
  endtask

  task automatic test_x0_filter();
    clear_log();
    alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h2121;
    ld_valid  = 1'b1; ld_rd  = 5'd3;  ld_data  = 32'h33;
    step();
    n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL x0_prefill got %0d exp 1", q_count); end
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD;
    ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 32'h44;
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b exp 1", ld_ready); end
    step();
    idle();
    n_checks++; if (Register_write !== 1'b1 || Rd !== 5'd3 || WriteData !== 32'h33) begin
      n_fail++; $display("FAIL x0_issue got wr=%b rd=%0d data=%h exp wr=1 rd=3 data=33", Register_write, Rd, WriteData);
    end
    n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL x0_count got %0d exp 0", q_count); end
    step();
    n_checks++; if (Register_write !== 1'b0) begin n_fail++; $display("FAIL x0_no_write got %b exp 0", Register_write); end
    n_checks++; if (log_rd.size() !== 2) begin n_fail++; $display("FAIL x0_writes got %0d exp 2", log_rd.size()); end
  endtask

  task automatic test_wrap();
    localparam int N = 3 * DEPTH;
    logic [4:0]  got_rd[$];
    logic [31:0] got_data[$];
    int          cyc;
    int          waited;
    logic        done;
    clear_log();
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) begin
        ld_valid  = 1'b0;
        alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'd31; alu_data = 32'hE000 + cyc;
        cyc++;
        step();
      end
      ld_valid = 1'b1; ld_rd = 5'((i % 30) + 1); ld_data = 32'hC000 + i;
      done = 1'b0;
      waited = 0;
      while (!done && waited < 40) begin
        alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'd31; alu_data = 32'hE000 + cyc;
        cyc++;
        done = ld_ready;
        step();
        waited++;
      end
      n_checks++; if (!done) begin n_fail++; $display("FAIL wrap_handshake_%0d got timeout exp accept", i); end
    end
    idle();
    repeat (20) step();
    for (int k = 0; k < log_rd.size(); k++) begin
      if (log_rd[k] != 5'd31) begin
        got_rd.push_back(log_rd[k]);
        got_data.push_back(log_data[k]);
      end
    end
    n_checks++;
    if (got_rd.size() !== N) begin
      n_fail++; $display("FAIL wrap_writes got %0d exp %0d", got_rd.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (got_rd[i] !== 5'((i % 30) + 1) || got_data[i] !== 32'hC000 + i) begin
          n_fail++; $display("FAIL wrap_order_%0d got rd=%0d data=%h exp rd=%0d data=%h", i, got_rd[i], got_data[i], (i % 30) + 1, 32'hC000 + i);
        end
      end
    end
    n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL wrap_empty got %0d exp 0", q_count); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_priority_fill();
    test_order_hazard();
    test_x0_filter();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-side front end for the 32 x 32 register file. Collects register writes from two producers, the single-cycle ALU path and the variable-latency load unit. Drives the file's single write port (`Register_write`, `Rd`, `WriteData`) with at most one write per cycle. Preserves program order per destination register and publishes a pending-write mask to the hazard/stall logic.

## Interface
- `DEPTH`, 4, load-return FIFO entries; power of two, >= 2
- `DW`, 32, data width
- `AW`, 5, register index width
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low reset
- `alu_valid` in 1: ALU result present this cycle; always accepted
- `alu_rd` in AW: ALU destination
- `alu_data` in DW: ALU result
- `ld_valid` in 1: load return offered
- `ld_ready` out 1: queue can accept a load return; equals `!full`
- `ld_rd` in AW: load destination
- `ld_data` in DW: load data
- `Register_write` out 1: write strobe to the register file (registered)
- `Rd` out AW: write index (registered)
- `WriteData` out DW: write data (registered)
- `pending_mask` out 32: bit r is set while any live queued entry targets r (combinational from queue state)
- `q_count` out clog2(DEPTH)+1: number of occupied FIFO slots, including killed ones

## Operation
- Load handshake: an entry is enqueued when `ld_valid && ld_ready`. When `ld_rd == 0`, the handshake completes but nothing is enqueued.
- FIFO entry fields: {live, rd, data}. New entries are live.
- Issue selection each cycle, in priority order:
  1. `alu_valid && alu_rd != 0`: issue the ALU write.
  2. Else, if the FIFO is non-empty: pop the head. Issue it only if the head is live; a killed head pops with `Register_write = 0`.
  3. Else: issue nothing.
- ALU write to x0: dropped. It neither issues nor blocks a pop.
- Order rule: when an ALU write to rd is issued, every live entry with a matching rd is cleared to killed in the same cycle. This covers both queued entries and one being enqueued that cycle. A younger ALU value is never overwritten by an older load.
- Simultaneous enqueue and pop on a full FIFO: the pop occurs, but `ld_ready` is low, so no enqueue.
- Pointers: rd/wr pointers of clog2(DEPTH)+1 bits. Full when the low bits are equal and the MSBs differ. Wrap-around is natural.
- `pending_mask`: OR over live entries of the one-hot decoded rd. Bit 0 is always 0.

## Timing
- Latency: a write selected in cycle N appears on `Register_write/Rd/WriteData` after edge N+1. The register file commits it at edge N+2.
- Minimum load-return latency (enqueue into an empty FIFO, no ALU traffic): enqueue at edge E, pop selected in the following cycle, outputs valid after E+1.
- Throughput: one write per cycle. A continuous stream of ALU writes starves the FIFO. This is by design; the producer throttles via `pending_mask`.
- Reset (low, asynchronous): FIFO empty, all entries killed, pointers 0. Outputs after reset:
  - `Register_write = 0`, `Rd = 0`, `WriteData = 0`
  - `ld_ready = 1`
  - `pending_mask = 0`, `q_count = 0`
- Reset asserted mid-operation discards all queued and in-flight writes immediately. The first write after deassertion needs a fresh request.
- `Register_write` is low in any cycle with no issue. `Rd/WriteData` hold their last value.

## Structure
- Shared package `rv_pkg`: `REG_CNT = 32`, `AW`, `DW`, and a `wb_entry_t` struct {live, rd, data}.
- One sub-module is natural: `wb_fifo`, a parameterised circular buffer with a per-entry kill-by-rd port. The top holds issue arbitration, x0 filtering and output registers.

## Test plan
- Reset value check: drive reset low mid-stream with 3 entries queued. Required: `Register_write = 0`, `q_count = 0`, `pending_mask = 0`, `ld_ready = 1`. No write occurs after release.
- Single load: load rd=5, data=0xDEAD into an empty queue, no ALU traffic. Required: one cycle with `Register_write = 1`, `Rd = 5`, `WriteData = 0xDEAD`. `pending_mask[5]` is high for exactly one cycle.
- Priority and fill: ALU writes every cycle while 4 loads (rd = 1..4) arrive. Required: `ld_ready` falls after the 4th load, `q_count = 4`. When the ALU stops, the loads drain in order 1, 2, 3, 4.
- Order hazard: queue a load rd=7, data=0x11, then issue ALU rd=7, data=0x22 before it drains. Required: the final x7 write is 0x22, the killed entry pops with no strobe, and `pending_mask[7]` clears.
- x0 filtering: ALU rd=0 with a FIFO head rd=3 queued, plus a load with rd=0 offered. Required: rd=3 issues that cycle, and the rd=0 load handshakes without `q_count` changing.
- Wrap-around: push and pop 3*DEPTH distinct loads with random ld_valid gaps. Required: exact in-order writes and no loss or duplication.
